// File: rtl/mult_share_pkg.sv
// Shared constants and helpers for the time-shared multiplier scheduler.
package mult_share_pkg;

    localparam int DATA_W = 12;
    localparam int PROD_W = 2 * DATA_W;

    // Ceiling log2, used to size requester indices (value 2..8 -> 1..3).
    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Request, multiplier and response bus of the shared-multiplier scheduler.
// The slave side is the scheduler, the master side is requesters + multiplier.
interface mult_share_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int ID_W    = 2
);
    logic                      Enable;
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ-1:0]        ReqReady;
    logic [NUM_REQ*DATA_W-1:0] ReqDataA;
    logic [NUM_REQ*DATA_W-1:0] ReqDataB;
    logic                      MulClkEn;
    logic [DATA_W-1:0]         MulDataA;
    logic [DATA_W-1:0]         MulDataB;
    logic [2*DATA_W-1:0]       MulResult;
    logic                      RespValid;
    logic [ID_W-1:0]           RespId;
    logic [2*DATA_W-1:0]       RespData;
    logic [ID_W+1:0]           InFlight;

    modport slave (
        input  Enable, ReqValid, ReqDataA, ReqDataB, MulResult,
        output ReqReady, MulClkEn, MulDataA, MulDataB,
               RespValid, RespId, RespData, InFlight
    );

    modport master (
        output Enable, ReqValid, ReqDataA, ReqDataB, MulResult,
        input  ReqReady, MulClkEn, MulDataA, MulDataB,
               RespValid, RespId, RespData, InFlight
    );
endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap, grants the
// first active request, and moves the pointer just past the winner.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_f(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] nxt_ptr_s;
    logic [N-1:0]  gnt_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Priority search from the pointer; no grant while held in reset or disabled.
    always_comb begin
        int            sum_v;
        logic [IW-1:0] pos_v;
        logic          hit_v;
        sum_v   = 0;
        pos_v   = '0;
        hit_v   = 1'b0;
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_v = int'(ptr_r) + k;
            if (sum_v >= N) begin
                sum_v = sum_v - N;
            end else begin
                sum_v = sum_v;
            end
            pos_v        = IW'(sum_v);
            hit_v        = en & rst_n & req[pos_v] & ~found_s;
            gnt_s[pos_v] = gnt_s[pos_v] | hit_v;
            idx_s        = hit_v ? pos_v : idx_s;
            found_s      = found_s | hit_v;
        end
    end

    // Next pointer is one past the winner, wrapping at N.
    always_comb begin
        int nsum_v;
        nsum_v = int'(idx_s) + 1;
        if (nsum_v >= N) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = IW'(nsum_v);
        end
    end

    // Pointer register: advances only on a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (en && found_s) begin
            ptr_r <= nxt_ptr_s;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;
    assign gnt_vld = found_s;

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one pipelined signed multiplier among NUM_REQ requesters.
// A {valid, id} tag travels alongside each operation so that the result can be
// returned with its requester index when it leaves the multiplier.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    mult_share_sched_if.slave bus
);

    localparam int ID_W  = clog2_f(NUM_REQ);
    localparam int L     = 1 + MULT_LAT;
    localparam int CNT_W = ID_W + 2;

    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               hs_s;
    logic [DATA_W-1:0]  a_sel_s;
    logic [DATA_W-1:0]  b_sel_s;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [L-1:0]       vld_r;
    logic [ID_W-1:0]    id_r [L];
    logic [CNT_W-1:0]   cnt_r;
    logic               resp_take_s;
    logic [PROD_W-1:0]  resp_data_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .en      (bus.Enable),
        .req     (bus.ReqValid),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (hs_s)
    );

    // One-hot operand select of the winning requester.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s = a_sel_s | (bus.ReqDataA[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
            b_sel_s = b_sel_s | (bus.ReqDataB[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
        end
    end

    // Issue registers feeding the multiplier; hold when nothing is issued.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            a_r <= '0;
            b_r <= '0;
        end else if (hs_s) begin
            a_r <= a_sel_s;
            b_r <= b_sel_s;
        end
    end

    // Tag pipeline matched to issue register plus multiplier latency.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            vld_r <= '0;
            for (int i = 0; i < L; i++) begin
                id_r[i] <= '0;
            end
        end else if (bus.Enable) begin
            vld_r   <= {vld_r[L-2:0], hs_s};
            id_r[0] <= gnt_idx_s;
            for (int i = 1; i < L; i++) begin
                id_r[i] <= id_r[i-1];
            end
        end
    end

    // A held RespValid is consumed only on an enabled cycle.
    assign resp_take_s = vld_r[L-1] & bus.Enable;

    // Outstanding-operation counter.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            cnt_r <= '0;
        end else begin
            case ({hs_s, resp_take_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Product is passed through only while a tagged result is at the output stage.
    always_comb begin
        resp_data_s = '0;
        if (vld_r[L-1]) begin
            resp_data_s = bus.MulResult;
        end else begin
            resp_data_s = '0;
        end
    end

    assign bus.ReqReady  = gnt_s;
    assign bus.MulClkEn  = bus.Enable;
    assign bus.MulDataA  = a_r;
    assign bus.MulDataB  = b_r;
    assign bus.RespValid = vld_r[L-1];
    assign bus.RespId    = id_r[L-1];
    assign bus.RespData  = resp_data_s;
    assign bus.InFlight  = cnt_r;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural 2-stage multiplier.
module tb_mult_share_sched;
    import mult_share_pkg::*;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int ML  = 2;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mult_share_sched_if #(.NUM_REQ(NR), .DATA_W(DATA_W), .ID_W(IDW)) bus ();

    mult_share_sched #(.NUM_REQ(NR), .MULT_LAT(ML)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    // Behavioural multiplier: MULT_LAT enabled stages from operands to result.
    logic signed [PROD_W-1:0] mp_r [ML] = '{default: '0};
    always @(posedge Clock) begin
        if (bus.MulClkEn) begin
            mp_r[0] <= $signed(bus.MulDataA) * $signed(bus.MulDataB);
            for (int i = 1; i < ML; i++) mp_r[i] <= mp_r[i-1];
        end
    end
    assign bus.MulResult = mp_r[ML-1];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic v, input int id, input int data);
        chk({tag, "_valid"}, {31'd0, bus.RespValid}, {31'd0, v});
        if (v) begin
            chk({tag, "_id"}, {30'd0, bus.RespId}, 32'(id));
            chk({tag, "_data"}, {8'd0, bus.RespData}, {8'd0, 24'(data)});
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.ReqDataA[i*DATA_W +: DATA_W] = 12'(a);
        bus.ReqDataB[i*DATA_W +: DATA_W] = 12'(b);
    endtask

    logic [3:0] rv_t  [6] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    logic [3:0] gnt_t [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    int         id_t  [4] = '{1, 3, 1, 3};
    int         dat_t [4] = '{35, -4192256, 4194304, -4192256};

    initial begin
        bus.Enable   = 1'b1;
        bus.ReqValid = '0;
        bus.ReqDataA = '0;
        bus.ReqDataB = '0;

        // Reset state, including no grant while reset is held.
        Reset_n = 1'b0;
        tick();
        tick();
        bus.ReqValid = 4'hF;
        #1;
        chk("rst_ready", {28'd0, bus.ReqReady}, 32'd0);
        chk_resp("rst_resp", 1'b0, 0, 0);
        chk("rst_id", {30'd0, bus.RespId}, 32'd0);
        chk("rst_data", {8'd0, bus.RespData}, 32'd0);
        chk("rst_inflight", {28'd0, bus.InFlight}, 32'd0);
        chk("rst_mula", {20'd0, bus.MulDataA}, 32'd0);
        bus.ReqValid = '0;
        Reset_n = 1'b1;
        tick();

        // All four requesting for 8 cycles: A = i+1, B = 2.
        for (int i = 0; i < NR; i++) set_op(i, i + 1, 2);
        for (int c = 0; c < 10; c++) begin
            bus.ReqValid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) chk("rr_grant", {28'd0, bus.ReqReady}, 32'(1 << (c % 4)));
            tick();
            chk("rr_inflight", {28'd0, bus.InFlight}, 32'((c < 2) ? c + 1 : ((c < 8) ? 3 : 10 - c)));
            chk_resp("rr_resp", c >= 2, (c >= 2) ? (c - 2) % 4 : 0, (c >= 2) ? 2 * ((c - 2) % 4 + 1) : 0);
        end
        tick();
        chk_resp("rr_drain", 1'b0, 0, 0);
        chk("rr_drain_inflight", {28'd0, bus.InFlight}, 32'd0);

        // Single request: 3 * -5 from requester 0.
        set_op(0, 3, -5);
        bus.ReqValid = 4'b0001;
        #1;
        chk("single_ready", {28'd0, bus.ReqReady}, 32'h1);
        tick();
        bus.ReqValid = '0;
        chk("single_inflight", {28'd0, bus.InFlight}, 32'd1);
        chk("single_mula", {20'd0, bus.MulDataA}, 32'h003);
        chk("single_mulb", {20'd0, bus.MulDataB}, 32'hFFB);
        chk_resp("single_lat0", 1'b0, 0, 0);
        tick();
        chk_resp("single_lat1", 1'b0, 0, 0);
        tick();
        chk_resp("single_resp", 1'b1, 0, -15);
        chk("single_raw", {8'd0, bus.RespData}, 32'h00FFFFF1);
        tick();
        chk_resp("single_after", 1'b0, 0, 0);
        chk("single_inflight0", {28'd0, bus.InFlight}, 32'd0);

        // Requesters 1 and 3 only with extreme operands (pointer moves to 2 first).
        set_op(1, 5, 7);
        set_op(3, 2047, -2048);
        for (int k = 0; k < 6; k++) begin
            bus.ReqValid = rv_t[k];
            #1;
            if (k < 4) chk("pair_grant", {28'd0, bus.ReqReady}, {28'd0, gnt_t[k]});
            tick();
            if (k == 0) set_op(1, -2048, -2048);
            chk_resp("pair_resp", k >= 2, (k >= 2) ? id_t[k-2] : 0, (k >= 2) ? dat_t[k-2] : 0);
        end
        tick();
        chk_resp("pair_drain", 1'b0, 0, 0);
        chk("pair_inflight", {28'd0, bus.InFlight}, 32'd0);

        // Enable low for 2 cycles with 2 ops in flight.
        set_op(0, -7, 9);
        set_op(2, 100, 100);
        bus.ReqValid = 4'b0001;
        #1;
        chk("gap_grant0", {28'd0, bus.ReqReady}, 32'h1);
        tick();
        bus.ReqValid = 4'b0100;
        #1;
        chk("gap_grant2", {28'd0, bus.ReqReady}, 32'h4);
        tick();
        bus.Enable   = 1'b0;
        bus.ReqValid = 4'hF;
        #1;
        chk("gap_ready", {28'd0, bus.ReqReady}, 32'd0);
        chk("gap_clken", {31'd0, bus.MulClkEn}, 32'd0);
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("gap_ready_hold", {28'd0, bus.ReqReady}, 32'd0);
            chk("gap_inflight", {28'd0, bus.InFlight}, 32'd2);
            chk_resp("gap_resp", 1'b0, 0, 0);
        end
        bus.Enable   = 1'b1;
        bus.ReqValid = '0;
        tick();
        chk_resp("gap_resp0", 1'b1, 0, -63);
        tick();
        chk_resp("gap_resp2", 1'b1, 2, 10000);
        tick();
        chk_resp("gap_drain", 1'b0, 0, 0);
        chk("gap_inflight0", {28'd0, bus.InFlight}, 32'd0);

        // Reset with 3 ops in flight (pointer at 3: grants 3, 0, 1).
        for (int i = 0; i < NR; i++) set_op(i, i + 1, 3);
        bus.ReqValid = 4'hF;
        #1;
        chk("mid_grant3", {28'd0, bus.ReqReady}, 32'h8);
        tick();
        chk("mid_grant0", {28'd0, bus.ReqReady}, 32'h1);
        tick();
        chk("mid_grant1", {28'd0, bus.ReqReady}, 32'h2);
        tick();
        bus.ReqValid = '0;
        chk("mid_inflight3", {28'd0, bus.InFlight}, 32'd3);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("mid_rst_inflight", {28'd0, bus.InFlight}, 32'd0);
        chk_resp("mid_rst_resp", 1'b0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            tick();
            chk_resp("mid_no_resp", 1'b0, 0, 0);
            chk("mid_inflight", {28'd0, bus.InFlight}, 32'd0);
        end
        bus.ReqValid = 4'hF;
        #1;
        chk("mid_next_grant", {28'd0, bus.ReqReady}, 32'h1);
        tick();
        bus.ReqValid = '0;
        chk("mid_next_inflight", {28'd0, bus.InFlight}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
